in_port_fifo: RTL
=================

// Module: in_port_fifo
// PURPOSE
//  Buffered input port for the single-cycle CPU. An external device pushes bytes via valid/ready.
//  The CPU pops them with a read strobe decoded from its IN instruction.
//  rd_data feeds the register-file write-data mux, so one IN writes one byte into a register.
//  A status byte (fill level, sticky error flags) can be read on the same data path.
// PARAMETERS
//  WIDTH  8  data width; must match the register-file word
//  DEPTH  4  FIFO entries; power of two, >=2
//  CW     $clog2(DEPTH+1)  width of count (derived; do not override)
// PORTS
//  clk        in   1      system clock; all state changes on posedge
//  reset      in   1      synchronous, active-high
//  dev_valid  in   1      device offers dev_data this cycle
//  dev_data   in   WIDTH  device byte
//  dev_ready  out  1      FIFO accepts a byte this cycle
//  cpu_rd     in   1      CPU IN strobe; pops head at posedge
//  cpu_stat   in   1      1: rd_data = status byte, no pop; 0: rd_data = FIFO head
//  err_clr    in   1      clears the sticky ovf/udf flags
//  rd_data    out  WIDTH  combinational read data to CPU
//  empty      out  1      count==0
//  full       out  1      count==DEPTH
//  count      out  CW     occupancy, 0..DEPTH
// BEHAVIOUR
//  - Storage: DEPTH x WIDTH array, wr_ptr/rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH.
//    count is held as a separate register.
//  - Reset (sync, has priority over every other input):
//    wr_ptr=rd_ptr=0, count=0, ovf=udf=0, so empty=1, full=0, dev_ready=1.
//    Array contents are not cleared.
//  - dev_ready = !full (combinational; it does not depend on cpu_rd).
//  - push = dev_valid & dev_ready: store dev_data at wr_ptr and increment wr_ptr.
//  - pop = cpu_rd & !cpu_stat & !empty: increment rd_ptr.
//  - count rules:
//    - push only: count+1
//    - pop only: count-1
//    - push & pop in the same cycle: count unchanged, both pointers advance
//    - neither: hold
//  - First-word fall-through:
//    - cpu_stat=0, !empty: rd_data = mem[rd_ptr]
//    - cpu_stat=0, empty: rd_data = 0
//    - A byte pushed at edge N is readable after edge N (zero-cycle read latency for the CPU).
//  - Status byte (cpu_stat=1): rd_data = {udf, ovf, full, empty, count zero-extended/truncated
//    into bits[3:0]}. Bits 7..4 = udf, ovf, full, empty. Reading status never pops.
//  - Overflow: dev_valid & full -> byte is dropped and ovf is set (sticky).
//  - Underflow: cpu_rd & !cpu_stat & empty -> no pointer change, rd_data=0, udf is set (sticky).
//  - err_clr clears ovf/udf at the edge. If a new error occurs in the same cycle, set wins.
//  - cpu_rd with cpu_stat=1 is a status read only: no pop, no udf.
//  - Reset while dev_valid=1: the byte is not stored. dev_ready returns to 1 in the cycle after reset.
//  - No combinational path from dev_valid to dev_ready, or from cpu_rd to rd_data.
// TESTING
//  1. Reset, then idle -> empty=1, full=0, count=0, dev_ready=1, status byte=8'h10.
//  2. Push 8'hA1, 8'hB2 on consecutive cycles, then cpu_rd twice
//     -> rd_data 8'hA1 then 8'hB2, count 2->1->0, empty=1.
//  3. Push 5 bytes 8'h01..8'h05 with DEPTH=4, no reads
//     -> full=1 after the 4th push, dev_ready=0, 8'h05 dropped, ovf=1, status=8'h64.
//     Then pop 4 -> 01,02,03,04.
//  4. From count=2, push 8'h77 and pop in the same cycle
//     -> count stays 2, the head advances, and 8'h77 is read after the remaining older byte.
//  5. cpu_rd on empty FIFO -> rd_data=0, udf=1, count=0. Then err_clr -> status=8'h10.
//  6. Fill 3 entries, assert reset for 1 cycle with dev_valid=1
//     -> count=0, empty=1, ovf=udf=0. The next push/pop pair returns the new byte.
//  7. Pointer wrap: 10 push/pop pairs of 8'h10..8'h19 interleaved
//     -> data returned in order across the wrap, count never above 1.

Source files
------------

// File: rtl/in_port_fifo.sv
// in_port_fifo: byte-wide input port FIFO for the single-cycle CPU.
// The device side pushes through a valid/ready handshake. The CPU side reads the head
// combinationally (first-word fall-through) and pops it with its IN strobe.
// A status byte of {udf, ovf, full, empty, count} can be read on the same data path.
module in_port_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dev_valid,
   input  logic [WIDTH-1:0] dev_data,
   output logic             dev_ready,
   input  logic             cpu_rd,
   input  logic             cpu_stat,
   input  logic             err_clr,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             ovf;
   logic             udf;
   logic             push;
   logic             pop;
   logic             ovf_evt;
   logic             udf_evt;
   logic [3:0]       cnt4;
   logic [WIDTH-1:0] stat;

   // Status flags and the handshake are functions of registered occupancy only,
   // so neither dev_valid nor cpu_rd reaches dev_ready or rd_data combinationally.
   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign dev_ready = !full;

   assign push    = dev_valid & dev_ready;
   assign pop     = cpu_rd & !cpu_stat & !empty;
   assign ovf_evt = dev_valid & full;
   assign udf_evt = cpu_rd & !cpu_stat & empty;

   // Count is zero-extended or truncated into the low nibble of the status byte.
   assign cnt4 = 4'(count);

   // Read mux: status byte, FIFO head, or zero when the FIFO is empty.
   always_comb begin
      stat      = '0;
      stat[3:0] = cnt4;
      stat[7:4] = {udf, ovf, full, empty};
      if (cpu_stat)
         rd_data = stat;
      else if (empty)
         rd_data = '0;
      else
         rd_data = mem[rd_ptr];
   end

   // Storage write. The array is not cleared on reset, but a byte offered while reset is high is not stored.
   always_ff @(posedge clk) begin
      if (push && !reset)
         mem[wr_ptr] <= dev_data;
   end

   // Pointers, occupancy and the sticky error flags. For the flags, a new error in the same cycle wins over err_clr.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (ovf_evt)
            ovf <= 1'b1;
         else if (err_clr)
            ovf <= 1'b0;
         if (udf_evt)
            udf <= 1'b1;
         else if (err_clr)
            udf <= 1'b0;
      end
   end

endmodule
